cla_sub_pipe: RTL and testbench
===============================

# cla_sub_pipe

Two-stage pipelined carry-lookahead subtractor computing diff = a − b − bin over WIDTH bits, with valid/ready handshakes on both sides. It is the subtracting counterpart to the team's combinational CLA adder (`main`). It sits between an operand producer and a result consumer, and sustains one operation per cycle under backpressure. Lookahead is organised in groups of GROUP bits, so the carry path is split across the two stages.

## Interface
- WIDTH, 10, operand/result width in bits (≥ 2, even)
- GROUP, WIDTH/2, lookahead group size; stage 1 handles the low GROUP bits, stage 2 the rest
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; sampled on rising clk edge
- in_valid  input  1  operand beat valid
- in_ready  output  1  stage 1 can accept a beat
- a  input  WIDTH  minuend, unsigned (also read as two's complement for ovf)
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow of a − b − bin

## Operation
- Subtraction is implemented as a + ~b + (1 − bin). Internal carry c = ~borrow.
- bout = ~carry_out(MSB).
- ovf = carry into MSB XOR carry out of MSB.
- Stage 1 captures the following on an accepted beat:
  - low GROUP bits of diff
  - carry out of the low group (group G | P·cin form)
  - a[WIDTH-1:GROUP] and ~b[WIDTH-1:GROUP]
- Stage 2 computes the upper group with GROUP-level lookahead from the captured carry, then registers diff, bout and ovf.
- Each stage has a valid bit: s1_v, s2_v (s2_v drives out_valid).
- Advance rules:
  - s2 loads when s1_v && (!s2_v || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_v || !s2_v || out_ready.
- The pipeline carries no other state and has no state machine beyond the two valid bits.
- Data registers update only on load; they hold otherwise.

## Timing
- Reset (reset==0 at an edge):
  - s1_v = s2_v = 0, so out_valid = 0.
  - diff = 0, bout = 0, ovf = 0.
  - in_ready = 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats; nothing emerges afterwards.
- Latency: a beat accepted at edge N presents out_valid = 1 after edge N+1, provided it is not stalled.
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure:
  - While out_valid && !out_ready, diff/bout/ovf are held stable.
  - s1 may still fill once. After that, in_ready = 0.
  - No beat is lost or duplicated.
- Simultaneous events:
  - Drain and load in the same cycle on both stages is legal and is required for full throughput.
  - in_ready depends combinationally on out_ready; no combinational path from in_valid to in_ready.
- Wrap-around: diff is modulo 2^WIDTH.
  - 0 − 0 − 1 gives all ones with bout = 1.
  - 0 − (2^WIDTH − 1) − 1 = 0 with bout = 1.
- Inputs are sampled only when in_valid && in_ready. Values under in_valid = 0 are don't-care.

## Structure
- Shared package holds:
  - the default widths (WIDTH = 10, GROUP = 5)
  - a function computing group generate/propagate
- Sub-module cla_group: combinational GROUP-bit lookahead block with inputs x, y, cin and outputs s, g, p, cout. It is instantiated once per stage.
- Pipeline control (valid bits, ready logic) lives in cla_sub_pipe.

## Test plan
- Stream at full rate with out_ready = 1, bin = 0:
  - (10,6) → diff 4, bout 0
  - (43,22) → diff 21, bout 0
  - (97,143) → diff 978, bout 1
  - (530,520) → diff 10, bout 0
  - Expect back-to-back out_valid, first result 2 cycles after the first accept.
- Borrow-in and wrap:
  - (0,0,bin = 1) → diff 1023, bout 1
  - (1023,1023,bin = 0) → diff 0, bout 0
  - (0,1023,bin = 1) → diff 0, bout 1
- Signed overflow:
  - (511,1023) → diff 512, ovf 1
  - (512,1) → diff 511, ovf 1
  - (5,3) → ovf 0
- Backpressure:
  - Hold out_ready = 0 for 4 cycles with in_valid = 1 on a 6-beat stream.
  - Expect in_ready to drop after 2 beats are held, outputs to stay stable, and all 6 results to arrive in order with no loss or duplication.
- Reset mid-stream: assert reset = 0 for 1 cycle with 2 beats in flight. Expect out_valid = 0, diff = 0, in_ready = 1 next cycle, and no stale beat emitted.
- Random: 10,000 random a/b/bin with random in_valid/out_ready. Compare results in order against a reference model of a − b − bin.

Source files
------------

// File: rtl/cla_sub_pipe_pkg.sv
// Shared widths and the group generate/propagate reduction for the pipelined CLA subtractor.
// Pure combinational helpers; no latency or backpressure of its own.
package cla_sub_pipe_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int GROUP_DEF = WIDTH_DEF / 2;
  localparam int MAXW      = 32;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Folds bit-level g/p over bits [n-1:0] into one group G/P (bit 0 least significant).
  function automatic gp_t group_gp(input logic [MAXW-1:0] gv, input logic [MAXW-1:0] pv,
                                   input int n);
    gp_t r;
    r.g = 1'b0;
    r.p = 1'b1;
    for (int i = 0; i < MAXW; i++) begin
      if (i < n) begin
        r.g = gv[i] | (pv[i] & r.g);
        r.p = r.p & pv[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_sub_pipe_group.sv
// Combinational N-bit lookahead block: every bit carry is formed directly from cin.
// Zero latency; no handshake.
module cla_group
  import cla_sub_pipe_pkg::*;
#(
  parameter int N = GROUP_DEF
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         g,
  output logic         p,
  output logic         cout
);

  logic [MAXW-1:0] gv;
  logic [MAXW-1:0] pv;
  logic [N-1:0]    c;
  gp_t             grp;

  assign gv = MAXW'(x & y);
  assign pv = MAXW'(x ^ y);

  // Carry into bit i is the prefix G|P*cin over bits [i-1:0], not a ripple chain.
  always_comb begin
    gp_t pre;
    pre = '0;
    c   = '0;
    for (int i = 0; i < N; i++) begin
      pre  = group_gp(gv, pv, i);
      c[i] = pre.g | (pre.p & cin);
    end
  end

  assign grp  = group_gp(gv, pv, N);
  assign s    = x ^ y ^ c;
  assign g    = grp.g;
  assign p    = grp.p;
  assign cout = grp.g | (grp.p & cin);

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage CLA subtractor diff = a - b - bin; results appear one cycle after the accept edge.
// Full-rate under out_ready; when stalled, stage 1 fills once and then in_ready drops.
module cla_sub_pipe
  import cla_sub_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int HW = WIDTH - GROUP;

  typedef struct packed {
    logic [HW-1:0]    a_hi;
    logic [HW-1:0]    nb_hi;
    logic             c_lo;
    logic [GROUP-1:0] d_lo;
  } s1_t;

  logic s1_v;
  logic s2_v;
  logic s1_load;
  logic s2_load;
  s1_t  s1_dat;
  s1_t  s1_nxt;

  logic [GROUP-1:0] lo_s;
  logic             lo_g;
  logic             lo_p;
  logic             lo_cout;
  logic [HW-1:0]    hi_s;
  logic             hi_g;
  logic             hi_p;
  logic             hi_cout;
  logic             c_msb;
  logic             unused_grp;

  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign in_ready  = !s1_v || !s2_v || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_v;

  // a - b - bin == a + ~b + (1 - bin); internal carry is the inverted borrow.
  cla_group #(.N(GROUP)) u_lo (
    .x    (a[GROUP-1:0]),
    .y    (~b[GROUP-1:0]),
    .cin  (~bin),
    .s    (lo_s),
    .g    (lo_g),
    .p    (lo_p),
    .cout (lo_cout)
  );

  always_comb begin
    s1_nxt       = '0;
    s1_nxt.a_hi  = a[WIDTH-1:GROUP];
    s1_nxt.nb_hi = ~b[WIDTH-1:GROUP];
    s1_nxt.c_lo  = lo_g | (lo_p & ~bin);
    s1_nxt.d_lo  = lo_s;
  end

  cla_group #(.N(HW)) u_hi (
    .x    (s1_dat.a_hi),
    .y    (s1_dat.nb_hi),
    .cin  (s1_dat.c_lo),
    .s    (hi_s),
    .g    (hi_g),
    .p    (hi_p),
    .cout (hi_cout)
  );

  // Carry into the MSB recovered from its sum bit, avoiding an extra port.
  assign c_msb      = hi_s[HW-1] ^ s1_dat.a_hi[HW-1] ^ s1_dat.nb_hi[HW-1];
  assign unused_grp = ^{lo_cout, hi_g, hi_p};

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1_dat <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (s1_load)      s1_v <= 1'b1;
      else if (s2_load) s1_v <= 1'b0;

      if (s2_load)        s2_v <= 1'b1;
      else if (out_ready) s2_v <= 1'b0;

      if (s1_load) s1_dat <= s1_nxt;

      if (s2_load) begin
        diff <= {hi_s, s1_dat.d_lo};
        bout <= ~hi_cout;
        ovf  <= c_msb ^ hi_cout;
      end
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Randomized and directed bench for cla_sub_pipe against an arithmetic reference of a - b - bin.
module tb_cla_sub_pipe;

  localparam int W   = 10;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  typedef struct packed {
    logic         ovf;
    logic         bout;
    logic [W-1:0] diff;
  } res_t;

  res_t exp_q[$];

  cla_sub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input int av, input int bv, input int bi);
    res_t r;
    int   sa;
    int   sb;
    int   sr;
    sa     = (av >= MOD / 2) ? av - MOD : av;
    sb     = (bv >= MOD / 2) ? bv - MOD : bv;
    sr     = sa - sb - bi;
    r.diff = W'((av - bv - bi) & (MOD - 1));
    r.bout = (av < bv + bi);
    r.ovf  = (sr > MOD / 2 - 1) || (sr < -(MOD / 2));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, so it sees exactly what the next rising edge will use.
  logic   held_v = 1'b0;
  res_t   held;
  always @(negedge clk) begin
    res_t e;
    res_t got;
    got = {ovf, bout, diff};
    if (!reset) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) chk("stall_hold", got, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", got, e);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(a), int'(b), int'(bin)));
        accepts++;
      end
      held_v = out_valid && !out_ready;
      held   = got;
    end
  end

  task automatic send(input int av, input int bv, input int bi);
    logic rdy;
    int   n;
    a        = W'(av);
    b        = W'(bv);
    bin      = bi[0];
    in_valid = 1'b1;
    n        = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Directed vectors: a, b, bin, then hand-computed diff, bout, ovf.
  int vec[10][6] = '{
    '{10,   6,    0, 4,    0, 0},
    '{43,   22,   0, 21,   0, 0},
    '{97,   143,  0, 978,  1, 0},
    '{530,  520,  0, 10,   0, 0},
    '{0,    0,    1, 1023, 1, 0},
    '{1023, 1023, 0, 0,    0, 0},
    '{0,    1023, 1, 0,    1, 0},
    '{511,  1023, 0, 512,  1, 1},
    '{512,  1,    0, 511,  0, 1},
    '{5,    3,    0, 2,    0, 0}
  };

  initial begin
    res_t m;
    int   cyc;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Pin the reference model to the hand-computed table.
    for (int i = 0; i < 10; i++) begin
      m = model(vec[i][0], vec[i][1], vec[i][2]);
      chk($sformatf("model_diff_%0d", i), m.diff, vec[i][3]);
      chk($sformatf("model_bout_%0d", i), m.bout, vec[i][4]);
      chk($sformatf("model_ovf_%0d", i), m.ovf, vec[i][5]);
    end

    // Full-rate stream: out_valid low one cycle after the first accept, then back-to-back.
    fork
      begin
        for (int i = 0; i < 10; i++) send(vec[i][0], vec[i][1], vec[i][2]);
        in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        chk("latency_not_early", out_valid, 0);
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("b2b_valid_%0d", i), out_valid, 1);
        end
      end
    join
    idle(4);
    chk("drain_stream", exp_q.size(), 0);

    // Backpressure: consumer stalls 4 cycles while a 6-beat stream is offered.
    fork
      begin
        for (int i = 0; i < 6; i++) send(100 + 37 * i, 7 * i, i % 2);
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);
    chk("drain_bp", exp_q.size(), 0);

    // Reset with two beats in flight.
    send(300, 100, 0);
    send(200, 50, 1);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random valid/ready until 10,000 accepts.
    accepts = 0;
    cyc     = 0;
    while (accepts < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = W'($urandom);
      b         = W'($urandom);
      bin       = 1'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("random_accepts", (accepts >= 10000), 1);
    out_ready = 1'b1;
    idle(5);
    chk("drain_random", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
